// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - in-order instruction fetch stage with IF/ID register
// Tracks a memory handshake across stalls and branch redirects; one word per cycle when memory has no wait states.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        stall_in,
    input  logic        branch_taken_in,
    input  logic [31:0] branch_target_in,
    input  logic        imem_ready_in,
    input  logic [31:0] imem_data_in,
    output logic        imem_req_out,
    output logic [31:0] imem_addr_out,
    output logic [31:0] IR_out,
    output logic [31:0] PC_out,
    output logic        valid_out
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] pc_id_q, pc_id_d;
    logic        valid_q, valid_d;
    logic [31:0] hold_word_q, hold_word_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] saved_target_q, saved_target_d;

    logic [31:0] target_aligned;
    logic [31:0] pc_inc;

    assign target_aligned = {branch_target_in[31:2], 2'b00};
    assign pc_inc         = pc_q + 32'd4;

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        ir_d           = ir_q;
        pc_id_d        = pc_id_q;
        valid_d        = valid_q;
        hold_word_d    = hold_word_q;
        hold_pc_d      = hold_pc_q;
        saved_target_d = saved_target_q;

        case (state_q)
            FETCH: begin
                if (branch_taken_in) begin
                    valid_d = 1'b0;
                    ir_d    = 32'd0;
                    if (imem_ready_in) begin
                        pc_d = target_aligned;
                    end else begin
                        // Request is still in flight; its response must be swallowed first.
                        saved_target_d = target_aligned;
                        state_d        = DISCARD;
                    end
                end else if (stall_in) begin
                    if (imem_ready_in) begin
                        hold_word_d = imem_data_in;
                        hold_pc_d   = pc_q;
                        pc_d        = pc_inc;
                        state_d     = HOLD;
                    end
                end else if (imem_ready_in) begin
                    ir_d    = imem_data_in;
                    pc_id_d = pc_q;
                    valid_d = 1'b1;
                    pc_d    = pc_inc;
                end else begin
                    valid_d = 1'b0;
                    ir_d    = 32'd0;
                end
            end
            HOLD: begin
                if (branch_taken_in) begin
                    pc_d    = target_aligned;
                    valid_d = 1'b0;
                    ir_d    = 32'd0;
                    state_d = FETCH;
                end else if (!stall_in) begin
                    ir_d    = hold_word_q;
                    pc_id_d = hold_pc_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                valid_d = 1'b0;
                ir_d    = 32'd0;
                if (branch_taken_in) begin
                    saved_target_d = target_aligned;
                end
                if (imem_ready_in) begin
                    pc_d    = branch_taken_in ? target_aligned : saved_target_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            state_q        <= FETCH;
            pc_q           <= {RESET_PC[31:2], 2'b00};
            ir_q           <= 32'd0;
            pc_id_q        <= 32'd0;
            valid_q        <= 1'b0;
            hold_word_q    <= 32'd0;
            hold_pc_q      <= 32'd0;
            saved_target_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            ir_q           <= ir_d;
            pc_id_q        <= pc_id_d;
            valid_q        <= valid_d;
            hold_word_q    <= hold_word_d;
            hold_pc_q      <= hold_pc_d;
            saved_target_q <= saved_target_d;
        end
    end

    assign imem_req_out  = !reset_in && (state_q != HOLD);
    assign imem_addr_out = pc_q;
    assign IR_out        = ir_q;
    assign PC_out        = pc_id_q;
    assign valid_out     = valid_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        stall_in = 1'b0;
    logic        branch_taken_in = 1'b0;
    logic [31:0] branch_target_in = 32'd0;
    logic        imem_ready_in = 1'b0;
    logic [31:0] imem_data_in = 32'd0;
    logic        imem_req_out;
    logic [31:0] imem_addr_out;
    logic [31:0] IR_out;
    logic [31:0] PC_out;
    logic        valid_out;

    logic        w_reset = 1'b1;
    logic        w_ready = 1'b0;
    logic [31:0] w_data = 32'd0;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_ir;
    logic [31:0] w_pc;
    logic        w_valid;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_ir_q[$];
    logic [31:0] exp_pc_q[$];

    always #5 clk = ~clk;

    instruction_fetch_unit u_dut (
        .clk_in          (clk),
        .reset_in        (reset_in),
        .stall_in        (stall_in),
        .branch_taken_in (branch_taken_in),
        .branch_target_in(branch_target_in),
        .imem_ready_in   (imem_ready_in),
        .imem_data_in    (imem_data_in),
        .imem_req_out    (imem_req_out),
        .imem_addr_out   (imem_addr_out),
        .IR_out          (IR_out),
        .PC_out          (PC_out),
        .valid_out       (valid_out)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk_in          (clk),
        .reset_in        (w_reset),
        .stall_in        (1'b0),
        .branch_taken_in (1'b0),
        .branch_target_in(32'd0),
        .imem_ready_in   (w_ready),
        .imem_data_in    (w_data),
        .imem_req_out    (w_req),
        .imem_addr_out   (w_addr),
        .IR_out          (w_ir),
        .PC_out          (w_pc),
        .valid_out       (w_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h0:   mem_word = 32'hE3A0_0001;
            32'h4:   mem_word = 32'hE281_1002;
            32'h8:   mem_word = 32'hE590_2000;
            default: mem_word = 32'h1000_0000 + addr;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] ir, input logic [31:0] pc);
        exp_ir_q.push_back(ir);
        exp_pc_q.push_back(pc);
    endtask

    // One clock of the main DUT; memory answers with the word at the current address.
    task automatic cyc(input logic stall, input logic br, input logic [31:0] tgt, input logic rdy);
        stall_in         = stall;
        branch_taken_in  = br;
        branch_target_in = tgt;
        imem_ready_in    = rdy;
        imem_data_in     = rdy ? mem_word(imem_addr_out) : 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
    endtask

    task automatic wcyc(input logic rst, input logic rdy);
        w_reset = rst;
        w_ready = rdy;
        w_data  = rdy ? 32'h600D_F00D : 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
    endtask

    // An instruction is consumed by decode on an edge where it is valid, not stalled, not flushed.
    always @(negedge clk) begin
        if (!reset_in && valid_out && !stall_in && !branch_taken_in) begin
            if (exp_ir_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected ir=%h pc=%h expected none", IR_out, PC_out);
            end else begin
                chk("sb_ir", IR_out, exp_ir_q.pop_front());
                chk("sb_pc", PC_out, exp_pc_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout expected finish");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ir", IR_out, 32'd0);
        chk("rst_pc", PC_out, 32'd0);
        chk("rst_valid", {31'd0, valid_out}, 32'd0);
        chk("rst_req", {31'd0, imem_req_out}, 32'd0);
        reset_in = 1'b0;
        #1;
        chk("first_req", {31'd0, imem_req_out}, 32'd1);
        chk("first_addr", imem_addr_out, 32'd0);

        // zero-wait fetch, then two wait states at address 4
        push(32'hE3A0_0001, 32'h0);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            chk("wait_addr", imem_addr_out, 32'h4);
            chk("wait_req", {31'd0, imem_req_out}, 32'd1);
            if (i == 2) push(32'hE281_1002, 32'h4);
            cyc(0, 0, 0, (i == 2));
            if (i < 2) chk("wait_bubble", {31'd0, valid_out}, 32'd0);
        end

        // stall for three cycles while word@8 returns
        cyc(1, 0, 0, 1);
        chk("hold_req", {31'd0, imem_req_out}, 32'd0);
        chk("hold_ir", IR_out, 32'hE281_1002);
        chk("hold_valid", {31'd0, valid_out}, 32'd1);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("hold_req2", {31'd0, imem_req_out}, 32'd0);
        push(32'hE590_2000, 32'h8);
        cyc(0, 0, 0, 0);
        chk("release_addr", imem_addr_out, 32'hC);
        chk("release_req", {31'd0, imem_req_out}, 32'd1);

        // branch during a pending fetch of 0x10
        push(32'h1000_000C, 32'hC);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 32'h0000_0103, 0);
        chk("discard_addr", imem_addr_out, 32'h10);
        chk("discard_req", {31'd0, imem_req_out}, 32'd1);
        chk("discard_valid", {31'd0, valid_out}, 32'd0);
        cyc(0, 0, 0, 1);
        chk("redirect_addr", imem_addr_out, 32'h100);
        chk("redirect_valid", {31'd0, valid_out}, 32'd0);
        push(32'h1000_0100, 32'h100);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);

        // branch and stall together: flush wins
        cyc(1, 1, 32'h40, 1);
        chk("flush_valid", {31'd0, valid_out}, 32'd0);
        chk("flush_ir", IR_out, 32'd0);
        chk("flush_addr", imem_addr_out, 32'h40);

        // branch out of HOLD, then latest-wins retarget in DISCARD
        cyc(1, 0, 0, 1);
        chk("hold2_req", {31'd0, imem_req_out}, 32'd0);
        cyc(0, 1, 32'h80, 0);
        chk("holdbr_addr", imem_addr_out, 32'h80);
        chk("holdbr_valid", {31'd0, valid_out}, 32'd0);
        cyc(0, 1, 32'h300, 0);
        cyc(0, 1, 32'h401, 0);
        chk("latest_hold_addr", imem_addr_out, 32'h80);
        cyc(0, 0, 0, 1);
        chk("latest_addr", imem_addr_out, 32'h400);
        push(32'h1000_0400, 32'h400);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);

        // PC wrap and reset mid-wait on the second instance
        w_reset = 1'b0;
        #1;
        chk("wrap_first_addr", w_addr, 32'hFFFF_FFFC);
        chk("wrap_first_req", {31'd0, w_req}, 32'd1);
        wcyc(0, 1);
        chk("wrap_addr", w_addr, 32'h0);
        chk("wrap_ir", w_ir, 32'h600D_F00D);
        chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
        chk("wrap_valid", {31'd0, w_valid}, 32'd1);
        wcyc(0, 0);
        wcyc(1, 0);
        chk("midrst_ir", w_ir, 32'd0);
        chk("midrst_pc", w_pc, 32'd0);
        chk("midrst_valid", {31'd0, w_valid}, 32'd0);
        chk("midrst_req", {31'd0, w_req}, 32'd0);
        w_reset = 1'b0;
        #1;
        chk("midrst_addr", w_addr, 32'hFFFF_FFFC);
        chk("midrst_req_after", {31'd0, w_req}, 32'd1);

        chk("sb_leftover", exp_ir_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
